// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the two-port memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Owner of the response slot one cycle after a read is accepted.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } owner_t;

    // Longest run of consecutive cycles the iBus may be denied under fixed priority.
    localparam int MAX_WAIT_DEFAULT = 4;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_grant
//  Description : Grant decision between iBus and dBus. The default build uses
//                fixed dBus priority with an iBus starvation guard; defining
//                MEM_ARB_RR_EN selects a 2-way round-robin instead.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ibus_valid,
    input  logic i_dbus_valid,
    output logic o_grant_i,
    output logic o_grant_d
);

    logic w_grant_i;
    logic w_grant_d;

`ifdef MEM_ARB_RR_EN

    // Pointer names the requester that wins the next contended cycle.
    owner_t r_ptr;

    // Grant: single requester wins outright, contention goes to the pointer owner.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!rst) begin
            if (i_ibus_valid && i_dbus_valid) begin
                w_grant_i = (r_ptr == IBUS);
                w_grant_d = (r_ptr != IBUS);
            end else begin
                w_grant_i = i_ibus_valid;
                w_grant_d = i_dbus_valid;
            end
        end
    end

    // Pointer moves to the other requester after every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IBUS;
        end else if (w_grant_i) begin
            r_ptr <= DBUS;
        end else if (w_grant_d) begin
            r_ptr <= IBUS;
        end
    end

`else

    // Counter must hold MAX_WAIT; keep at least one bit for MAX_WAIT of 0.
    localparam int              SW         = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0]   c_MAX_WAIT = SW'(MAX_WAIT);
    localparam logic [SW-1:0]   c_ONE      = SW'(1);

    logic [SW-1:0] r_starve;

    // Grant: dBus wins contention unless the iBus has waited MAX_WAIT cycles.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!rst) begin
            if (i_ibus_valid && i_dbus_valid) begin
                w_grant_i = (r_starve == c_MAX_WAIT);
                w_grant_d = (r_starve != c_MAX_WAIT);
            end else begin
                w_grant_i = i_ibus_valid;
                w_grant_d = i_dbus_valid;
            end
        end
    end

    // Count consecutive iBus denials; clear when served or not requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!i_ibus_valid || w_grant_i) begin
            r_starve <= '0;
        end else if (r_starve != c_MAX_WAIT) begin
            r_starve <= r_starve + c_ONE;
        end
    end

`endif

    assign o_grant_i = w_grant_i;
    assign o_grant_d = w_grant_d;

endmodule : mem_arb_grant
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates an instruction bus and a data bus onto one
//                single-port SRAM with 1-cycle read latency. Read data is
//                passed straight through to whichever bus owns the response.
//                Build option: MEM_ARB_RR_EN selects round-robin arbitration
//                (default is fixed dBus priority with iBus starvation guard).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH    = 8192,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    // instruction fetch port
    input  logic                        i_cmd_valid,
    output logic                        i_cmd_ready,
    input  logic [31:0]                 i_cmd_addr,
    output logic                        i_rsp_valid,
    output logic [31:0]                 i_rsp_data,
    // data port
    input  logic                        d_cmd_valid,
    output logic                        d_cmd_ready,
    input  logic [31:0]                 d_cmd_addr,
    input  logic [31:0]                 d_cmd_wdata,
    input  logic [3:0]                  d_cmd_mask,
    input  logic                        d_cmd_wr,
    output logic                        d_rsp_valid,
    output logic [31:0]                 d_rsp_data,
    // SRAM port
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [$clog2(DEPTH)-1:0]    mem_addr,
    output logic [31:0]                 mem_wdata,
    output logic [3:0]                  mem_mask,
    input  logic [31:0]                 mem_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic   w_grant_i;
    logic   w_grant_d;
    owner_t r_rsp_owner;

    // Only the word index inside the memory is used; the rest of each
    // address is folded here so the wrap-around is explicit.
    logic   w_unused_addr;
    assign  w_unused_addr = ^{i_cmd_addr, d_cmd_addr};

    mem_arb_grant #(
        .MAX_WAIT     (MAX_WAIT)
    ) u_grant (
        .clk          (clk),
        .rst          (rst),
        .i_ibus_valid (i_cmd_valid),
        .i_dbus_valid (d_cmd_valid),
        .o_grant_i    (w_grant_i),
        .o_grant_d    (w_grant_d)
    );

    assign i_cmd_ready = w_grant_i;
    assign d_cmd_ready = w_grant_d;

    // Steer the granted command onto the SRAM in the same cycle.
    always_comb begin
        mem_en    = w_grant_i | w_grant_d;
        mem_we    = w_grant_d & d_cmd_wr;
        mem_addr  = w_grant_d ? d_cmd_addr[AW+1:2] : i_cmd_addr[AW+1:2];
        mem_wdata = w_grant_d ? d_cmd_wdata : 32'h0;
        mem_mask  = w_grant_d ? d_cmd_mask  : 4'h0;
    end

    // Remember who issued this cycle's read so next cycle's data is routed to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_owner <= NONE;
        end else if (w_grant_i) begin
            r_rsp_owner <= IBUS;
        end else if (w_grant_d && !d_cmd_wr) begin
            r_rsp_owner <= DBUS;
        end else begin
            r_rsp_owner <= NONE;
        end
    end

    // A read in flight when reset arrives is dropped rather than delivered.
    assign i_rsp_valid = (r_rsp_owner == IBUS) && !rst;
    assign d_rsp_valid = (r_rsp_owner == DBUS) && !rst;
    assign i_rsp_data  = mem_rdata;
    assign d_rsp_data  = mem_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a
//                behavioural 1-cycle-latency SRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DEPTH = 8192;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid, i_cmd_ready;
    logic [31:0]   i_cmd_addr;
    logic          i_rsp_valid;
    logic [31:0]   i_rsp_data;
    logic          d_cmd_valid, d_cmd_ready;
    logic [31:0]   d_cmd_addr, d_cmd_wdata;
    logic [3:0]    d_cmd_mask;
    logic          d_cmd_wr;
    logic          d_rsp_valid;
    logic [31:0]   d_rsp_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_mask;
    logic [31:0]   mem_rdata = 32'h0;

    logic [31:0]   mem [0:DEPTH-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .i_cmd_addr  (i_cmd_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .d_cmd_valid (d_cmd_valid),
        .d_cmd_ready (d_cmd_ready),
        .d_cmd_addr  (d_cmd_addr),
        .d_cmd_wdata (d_cmd_wdata),
        .d_cmd_mask  (d_cmd_mask),
        .d_cmd_wr    (d_cmd_wr),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_mask    (mem_mask),
        .mem_rdata   (mem_rdata)
    );

    // SRAM model: byte-masked write, registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cmd_valid = 1'b0; i_cmd_addr = 32'h0;
        d_cmd_valid = 1'b0; d_cmd_addr = 32'h0; d_cmd_wdata = 32'h0;
        d_cmd_mask  = 4'h0; d_cmd_wr   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g;
        logic [1:0] prev_g;

        for (int k = 0; k < DEPTH; k++) mem[k] = 32'h0;
        mem[1] = 32'hA5A5_0001;
        mem[2] = 32'hFFFF_FFFF;
        mem[4] = 32'hDEAD_BEEF;

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();

        // Reset state with both requesters asserting.
        i_cmd_valid = 1'b1; d_cmd_valid = 1'b1;
        #4;
        check("rst_i_ready", {31'h0, i_cmd_ready}, 32'h0);
        check("rst_d_ready", {31'h0, d_cmd_ready}, 32'h0);
        check("rst_mem_en",  {31'h0, mem_en},      32'h0);
        check("rst_mem_we",  {31'h0, mem_we},      32'h0);
        check("rst_i_rsp",   {31'h0, i_rsp_valid}, 32'h0);
        check("rst_d_rsp",   {31'h0, d_rsp_valid}, 32'h0);

        // First cycle after reset: iBus read of word 4.
        tick();
        rst = 1'b0;
        idle_inputs();
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h0000_0010;
        #4;
        check("ird_ready",   {31'h0, i_cmd_ready}, 32'h1);
        check("ird_mem_en",  {31'h0, mem_en},      32'h1);
        check("ird_addr",    32'(mem_addr),        32'd4);
        check("ird_we",      {31'h0, mem_we},      32'h0);
        check("ird_mask",    {28'h0, mem_mask},    32'h0);
        tick();
        idle_inputs();
        #4;
        check("ird_rsp_v",   {31'h0, i_rsp_valid}, 32'h1);
        check("ird_rsp_d",   i_rsp_data,           32'hDEAD_BEEF);
        check("ird_d_rsp_v", {31'h0, d_rsp_valid}, 32'h0);
        check("idle_mem_en", {31'h0, mem_en},      32'h0);

        // dBus masked write to word 2.
        tick();
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h8; d_cmd_wdata = 32'h1234_5678;
        d_cmd_mask = 4'h3; d_cmd_wr = 1'b1;
        #4;
        check("dwr_ready",   {31'h0, d_cmd_ready}, 32'h1);
        check("dwr_we",      {31'h0, mem_we},      32'h1);
        check("dwr_addr",    32'(mem_addr),        32'd2);
        check("dwr_mask",    {28'h0, mem_mask},    32'h3);
        check("dwr_wdata",   mem_wdata,            32'h1234_5678);
        tick();
        idle_inputs();
        #4;
        check("dwr_no_rsp",  {31'h0, d_rsp_valid}, 32'h0);
        check("dwr_no_irsp", {31'h0, i_rsp_valid}, 32'h0);
        check("idle_we",     {31'h0, mem_we},      32'h0);

        // Read back the partially written word.
        tick();
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h8;
        tick();
        idle_inputs();
        #4;
        check("drd_rsp_v",   {31'h0, d_rsp_valid}, 32'h1);
        check("drd_rsp_d",   d_rsp_data,           32'hFFFF_5678);

        // Address wrap: byte 0x10004 lands on word 1.
        tick();
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h0001_0004;
        #4;
        check("wrap_addr",   32'(mem_addr),        32'd1);
        tick();
        // Back-to-back: iBus then dBus with no bubble.
        idle_inputs();
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h10;
        #4;
        check("b2b_d_ready", {31'h0, d_cmd_ready}, 32'h1);
        check("b2b_i_rsp_v", {31'h0, i_rsp_valid}, 32'h1);
        check("b2b_i_rsp_d", i_rsp_data,           32'hA5A5_0001);
        tick();
        idle_inputs();
        #4;
        check("b2b_d_rsp_v", {31'h0, d_rsp_valid}, 32'h1);
        check("b2b_d_rsp_d", d_rsp_data,           32'hDEAD_BEEF);
        check("b2b_i_rsp_0", {31'h0, i_rsp_valid}, 32'h0);

        // dBus read accepted, then reset next cycle drops the response.
        tick();
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h4;
        #4;
        check("rd_drop_acc", {31'h0, d_cmd_ready}, 32'h1);
        tick();
        rst = 1'b1;
        #4;
        check("drop_d_rsp",  {31'h0, d_rsp_valid}, 32'h0);
        check("drop_i_rsp",  {31'h0, i_rsp_valid}, 32'h0);
        check("drop_d_rdy",  {31'h0, d_cmd_ready}, 32'h0);
        check("drop_mem_en", {31'h0, mem_en},      32'h0);
        check("drop_mem_we", {31'h0, mem_we},      32'h0);

        // Contention from reset: both buses reading continuously.
        tick();
        rst = 1'b0;
        idle_inputs();
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h10;
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h4;
        prev_g = 2'b00;
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = (k % 5 == 4) ? 2'b10 : 2'b01;
`endif
            #4;
            check($sformatf("cont_grant_%0d", k), {30'h0, i_cmd_ready, d_cmd_ready}, {30'h0, exp_g});
            check($sformatf("cont_irsp_%0d", k),  {31'h0, i_rsp_valid}, {31'h0, prev_g[1]});
            check($sformatf("cont_drsp_%0d", k),  {31'h0, d_rsp_valid}, {31'h0, prev_g[0]});
            if (prev_g == 2'b10) check($sformatf("cont_idat_%0d", k), i_rsp_data, 32'hDEAD_BEEF);
            if (prev_g == 2'b01) check($sformatf("cont_ddat_%0d", k), d_rsp_data, 32'hA5A5_0001);
            prev_g = exp_g;
            tick();
        end
        idle_inputs();
        #4;
        check("cont_last_irsp", {31'h0, i_rsp_valid}, {31'h0, prev_g[1]});
        check("cont_last_drsp", {31'h0, d_rsp_valid}, {31'h0, prev_g[0]});

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8192, memory depth in 32-bit words; AW = $clog2(DEPTH) derived locally.
REQ-002 SHALL have parameter MAX_WAIT, default 4, max consecutive cycles iBus may be denied under fixed priority.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 i_cmd_valid in 1, i_cmd_ready out 1, i_cmd_addr in 32  instruction fetch request (byte address).
REQ-007 i_rsp_valid out 1, i_rsp_data out 32  fetch response; no backpressure.
REQ-008 d_cmd_valid in 1, d_cmd_ready out 1, d_cmd_addr in 32, d_cmd_wdata in 32, d_cmd_mask in 4, d_cmd_wr in 1 (1=write)  data request.
REQ-009 d_rsp_valid out 1, d_rsp_data out 32  data read response; no backpressure.
REQ-010 mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out 32, mem_mask out 4, mem_rdata in 32  single-port SRAM, 1-cycle read latency.

Function
REQ-011 SHALL grant at most one requester per cycle; cmd accepted when valid && ready.
REQ-012 i_cmd_ready/d_cmd_ready SHALL be combinational from grant; ready may depend on valid, never the reverse.
REQ-013 Granted cmd SHALL drive mem_en=1, mem_addr=addr[AW+1:2] same cycle; upper address bits ignored (wrap modulo DEPTH).
REQ-014 iBus grant SHALL drive mem_we=0, mem_mask=4'h0; dBus grant SHALL drive mem_we=d_cmd_wr, mem_mask=d_cmd_mask, mem_wdata=d_cmd_wdata.
REQ-015 Read accepted cycle N SHALL give rsp_valid=1 to the owner in cycle N+1 for one cycle, data = mem_rdata (combinational passthrough).
REQ-016 dBus writes SHALL produce no response.
REQ-017 SHALL sustain one accepted cmd per cycle (back-to-back) with no bubble.
REQ-018 Response ownership SHALL be held in a 1-entry register rsp_owner in {NONE, IBUS, DBUS}, loaded every cycle from the current grant (NONE if no read).
REQ-019 Fixed priority (default): dBus wins simultaneous requests, except when starve count == MAX_WAIT, then iBus wins.
REQ-020 Starve counter SHALL increment when i_cmd_valid && !grant_i, clear on iBus grant or !i_cmd_valid, saturate at MAX_WAIT.
REQ-021 Single requester SHALL be granted immediately regardless of priority state.
REQ-022 Idle (no valid) SHALL drive mem_en=0, mem_we=0.

Reset
REQ-023 During rst: both readies 0, mem_en=0, mem_we=0, rsp_owner=NONE, starve count 0, RR pointer = IBUS.
REQ-024 Read accepted the cycle before rst asserts SHALL be dropped: i_rsp_valid=d_rsp_valid=0 in the reset cycle.
REQ-025 First grant SHALL be possible the cycle after rst deasserts.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: fixed priority and starve counter removed; 2-way round-robin, pointer toggles to the other requester after each grant, contended cycle grants pointer owner.
REQ-027 Macro undefined: fixed priority with starvation guard per REQ-019/020.

Structure
REQ-028 Package mem_arb_pkg SHALL hold typedef enum owner_t {NONE, IBUS, DBUS} and constant MAX_WAIT_DEFAULT=4.
REQ-029 Grant logic (priority, starve counter, RR pointer) SHALL live in sub-module mem_arb_grant; datapath muxing and rsp_owner in mem_arbiter.

Verification
REQ-030 iBus read only, addr 0x0000_0010, mem word 4 = 0xDEADBEEF -> mem_addr=4 cycle N, i_rsp_valid=1, i_rsp_data=0xDEADBEEF cycle N+1.
REQ-031 dBus write addr 0x8, wdata 0x12345678, mask 4'h3 -> mem_we=1, mem_addr=2, mem_mask=3; no d_rsp_valid next cycle.
REQ-032 Both valid continuously, macro undefined -> grants D,D,D,D,I repeating; iBus denied never exceeds 4 cycles.
REQ-033 Both valid continuously, MEM_ARB_RR_EN defined -> grants I,D,I,D from reset.
REQ-034 dBus read accepted cycle N, rst=1 cycle N+1 -> d_rsp_valid=0 cycle N+1, all outputs at reset values.
REQ-035 iBus addr 0x0001_0004 with DEPTH=8192 -> mem_addr=1 (wrap).
